spi_reg_initiator: RTL and testbench

Byte-level command sequencer on the host side of the PWM register block. It consumes bytes from the SPI shift register, parses command bytes, and drives the register-file bus (`read`, `write`, `addr`, `data_write`, `data_read`). Read results go back to the SPI transmitter. The register file is the responder on this bus; this block is its only initiator.

---
 rtl/spi_reg_initiator.sv | 140 ++++++++++++++
 tb/tb_spi_reg_initiator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_initiator.sv
// Byte-level SPI command sequencer driving the register-file bus (read/write/addr/data).
// Define SPI_REG_AUTO_INC_EN to enable burst access with address auto-increment.
module spi_reg_initiator #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read,
  output logic              cmd_err
);

  // One-hot encoding so that read is a single flop bit with no decode glitches.
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    WDATA  = 5'b00010,
    RD     = 5'b00100,
    RDUMMY = 5'b01000,
    DRAIN  = 5'b10000
  } state_t;

  localparam int RD_BIT = 2;

  // Command bits between the address field and the R/W bit must be zero.
  localparam logic [6:0] HI_MASK = 7'(~((8'd1 << ADDR_W) - 8'd1));

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_write_q, data_write_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                write_q, write_d;
  logic                tx_load_q, tx_load_d;
  logic                cmd_err_q, cmd_err_d;
  logic                cmd_illegal;

  assign cmd_illegal = |(rx_byte[6:0] & HI_MASK);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_write_d = data_write_q;
    tx_byte_d    = tx_byte_q;
    write_d      = 1'b0;
    tx_load_d    = 1'b0;
    cmd_err_d    = 1'b0;

`ifdef SPI_REG_AUTO_INC_EN
    if (write_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end
`endif

    if (cs_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if (cmd_illegal) begin
              cmd_err_d = 1'b1;
              state_d   = DRAIN;
            end else begin
              addr_d  = rx_byte[ADDR_W-1:0];
              state_d = rx_byte[7] ? WDATA : RD;
            end
          end
        end
        WDATA: begin
          if (rx_valid) begin
            data_write_d = rx_byte;
            write_d      = 1'b1;
`ifdef SPI_REG_AUTO_INC_EN
            state_d      = WDATA;
`else
            state_d      = IDLE;
`endif
          end
        end
        RD: begin
          tx_byte_d = data_read;
          tx_load_d = 1'b1;
          state_d   = RDUMMY;
        end
        RDUMMY: begin
          if (rx_valid) begin
`ifdef SPI_REG_AUTO_INC_EN
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD;
`else
            state_d = IDLE;
`endif
          end
        end
        DRAIN: begin
          state_d = DRAIN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_write_q <= 8'h00;
      tx_byte_q    <= 8'h00;
      write_q      <= 1'b0;
      tx_load_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_write_q <= data_write_d;
      tx_byte_q    <= tx_byte_d;
      write_q      <= write_d;
      tx_load_q    <= tx_load_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign read       = state_q[RD_BIT];
  assign write      = write_q;
  assign addr       = addr_q;
  assign data_write = data_write_q;
  assign tx_byte    = tx_byte_q;
  assign tx_load    = tx_load_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_spi_reg_initiator.sv
// Directed self-checking bench for spi_reg_initiator; a small register array supplies data_read.
module tb_spi_reg_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       cmd_err;

  logic [7:0] mem [64];
  int errors = 0;
  int checks = 0;
  int read_count = 0;
  int overlap_count = 0;

  always #5 clk = ~clk;

  assign data_read = mem[addr];

  spi_reg_initiator #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load), .read(read), .write(write), .addr(addr),
    .data_write(data_write), .data_read(data_read), .cmd_err(cmd_err)
  );

  always @(negedge clk) begin
    if (read) read_count++;
    if (read && write) overlap_count++;
  end

  // Called #1 after a rising edge; returns #1 after the edge that consumed the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic end_txn();
    cs_n = 1'b1;
    idle(2);
    cs_n = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(1);
    checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b expected 0", read); end
    checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL reset_write: got %b expected 0", write); end
    checks++; if (tx_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_load: got %b expected 0", tx_load); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_err: got %b expected 0", cmd_err); end
    checks++; if (addr !== 6'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00", addr); end
    checks++; if (data_write !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_write: got %h expected 00", data_write); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    cs_n = 1'b0;
    idle(1);
  endtask

  task automatic test_write();
    int reads_before;
    reads_before = read_count;
    send_byte(8'h80);
    checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL wr_cmd_no_write: got %b expected 0", write); end
    send_byte(8'hA5);
    checks++; if (write !== 1'b1) begin errors++; $display("[TB] FAIL wr_strobe: got %b expected 1", write); end
    checks++; if (addr !== 6'h00) begin errors++; $display("[TB] FAIL wr_addr: got %h expected 00", addr); end
    checks++; if (data_write !== 8'hA5) begin errors++; $display("[TB] FAIL wr_data: got %h expected a5", data_write); end
    idle(1);
    checks++; if (write !== 1'b0) begin errors++; $display("[TB] FAIL wr_one_cycle: got %b expected 0", write); end
    checks++; if (read_count !== reads_before) begin errors++; $display("[TB] FAIL wr_no_read: got %0d reads expected %0d", read_count, reads_before); end
    end_txn();
  endtask

  task automatic test_read();
    send_byte(8'h08);
    checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL rd_strobe: got %b expected 1", read); end
    checks++; if (addr !== 6'h08) begin errors++; $display("[TB] FAIL rd_addr: got %h expected 08", addr); end
    checks++; if (tx_load !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_load: got %b expected 0", tx_load); end
    idle(1);
    checks++; if (tx_load !== 1'b1) begin errors++; $display("[TB] FAIL rd_tx_load: got %b expected 1", tx_load); end
    checks++; if (tx_byte !== 8'h3C) begin errors++; $display("[TB] FAIL rd_tx_byte: got %h expected 3c", tx_byte); end
    checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL rd_one_cycle: got %b expected 0", read); end
    idle(1);
    checks++; if (tx_load !== 1'b0) begin errors++; $display("[TB] FAIL rd_load_once: got %b expected 0", tx_load); end
    checks++; if (tx_byte !== 8'h3C) begin errors++; $display("[TB] FAIL rd_tx_hold: got %h expected 3c", tx_byte); end
    send_byte(8'h00);
`ifdef SPI_REG_AUTO_INC_EN
    checks++; if (read !== 1'b1 || addr !== 6'h09) begin errors++; $display("[TB] FAIL rd_burst_next: got read=%b addr=%h expected read=1 addr=09", read, addr); end
`else
    checks++; if (read !== 1'b0) begin errors++; $display("[TB] FAIL rd_dummy_idle: got %b expected 0", read); end
`endif
    end_txn();
  endtask

  task automatic test_illegal();
    send_byte(8'h40);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("[TB] FAIL ill_cmd_err: got %b expected 1", cmd_err); end
    idle(1);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL ill_cmd_err_pulse: got %b expected 0", cmd_err); end
    send_byte(8'h80);
    checks++; if (write !== 1'b0 || cmd_err !== 1'b0) begin errors++; $display("[TB] FAIL ill_drain_cmd: got write=%b cmd_err=%b expected 0 0", write, cmd_err); end
    send_byte(8'h11);
    checks++; if (write !== 1'b0 || read !== 1'b0) begin errors++; $display("[TB] FAIL ill_drain_data: got write=%b read=%b expected 0 0", write, read); end
    end_txn();
    send_byte(8'h81);
    send_byte(8'h22);
    checks++; if (write !== 1'b1) begin errors++; $display("[TB] FAIL ill_recover_write: got %b expected 1", write); end
    checks++; if (addr !== 6'h01 || data_write !== 8'h22) begin errors++; $display("[TB] FAIL ill_recover_bus: got addr=%h data=%h expected 01 22", addr, data_write); end
    end_txn();
  endtask

  task automatic test_abort();
    send_byte(8'h8D);
    checks++; if (addr !== 6'h0D) begin errors++; $display("[TB] FAIL abort_addr_latch: got %h expected 0d", addr); end
    cs_n = 1'b1;
    send_byte(8'h55);
    checks++; if (write !== 1'b0 || read !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_strobe: got write=%b read=%b expected 0 0", write, read); end
    checks++; if (addr !== 6'h0D) begin errors++; $display("[TB] FAIL abort_discard: got addr=%h expected 0d", addr); end
    cs_n = 1'b0;
    idle(1);
    send_byte(8'h82);
    checks++; if (write !== 1'b0 || read !== 1'b0 || addr !== 6'h02) begin errors++; $display("[TB] FAIL abort_next_cmd: got write=%b read=%b addr=%h expected 0 0 02", write, read, addr); end
    send_byte(8'h33);
    checks++; if (write !== 1'b1 || data_write !== 8'h33) begin errors++; $display("[TB] FAIL abort_next_write: got write=%b data=%h expected 1 33", write, data_write); end
    end_txn();
  endtask

  task automatic test_reset_mid_read();
    send_byte(8'h05);
    idle(1);
    checks++; if (tx_load !== 1'b1 || tx_byte !== 8'h5A) begin errors++; $display("[TB] FAIL rmr_before: got load=%b tx=%h expected 1 5a", tx_load, tx_byte); end
    rst = 1'b1;
    idle(1);
    checks++; if ({read, write, tx_load, cmd_err} !== 4'b0000) begin errors++; $display("[TB] FAIL rmr_strobes: got %b expected 0000", {read, write, tx_load, cmd_err}); end
    checks++; if (addr !== 6'h00 || data_write !== 8'h00 || tx_byte !== 8'h00) begin errors++; $display("[TB] FAIL rmr_regs: got addr=%h data=%h tx=%h expected 00 00 00", addr, data_write, tx_byte); end
    rst = 1'b0;
    idle(1);
    send_byte(8'h0D);
    checks++; if (read !== 1'b1 || addr !== 6'h0D) begin errors++; $display("[TB] FAIL rmr_read: got read=%b addr=%h expected 1 0d", read, addr); end
    idle(1);
    checks++; if (tx_load !== 1'b1 || tx_byte !== 8'hC3) begin errors++; $display("[TB] FAIL rmr_tx: got load=%b tx=%h expected 1 c3", tx_load, tx_byte); end
    idle(1);
    send_byte(8'h00);
    end_txn();
  endtask

  task automatic test_back_to_back();
    send_byte(8'hBF);
    send_byte(8'h01);
    checks++; if (write !== 1'b1 || addr !== 6'h3F || data_write !== 8'h01) begin errors++; $display("[TB] FAIL b2b_first: got write=%b addr=%h data=%h expected 1 3f 01", write, addr, data_write); end
    idle(1);
    send_byte(8'h02);
`ifdef SPI_REG_AUTO_INC_EN
    checks++; if (write !== 1'b1 || addr !== 6'h00 || data_write !== 8'h02) begin errors++; $display("[TB] FAIL b2b_wrap: got write=%b addr=%h data=%h expected 1 00 02", write, addr, data_write); end
`else
    checks++; if (read !== 1'b1 || write !== 1'b0 || addr !== 6'h02) begin errors++; $display("[TB] FAIL b2b_new_cmd: got read=%b write=%b addr=%h expected 1 0 02", read, write, addr); end
`endif
    end_txn();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[8]  = 8'h3C;
    mem[9]  = 8'h99;
    mem[5]  = 8'h5A;
    mem[13] = 8'hC3;
    mem[2]  = 8'h7E;
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    checks++; if (overlap_count !== 0) begin errors++; $display("[TB] FAIL read_write_overlap: got %0d cycles expected 0", overlap_count); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
